instruction_prefetch: RTL
=========================

// Module: instruction_prefetch
// PURPOSE
//  Parametrised instruction fetch stage with its own PC register and a FIFO_DEPTH-entry prefetch buffer.
//  Issues sequential word fetches over the imem req/ack handshake, at most one outstanding.
//  Buffers {pc, instruction} pairs for decode over a valid/ready interface.
//  Supports PC redirect (branch/jump/trap) with buffer flush and discard of an in-flight fetch.
//  Sits between the instruction memory port and the decode stage.
// PARAMETERS
//  MEM_ADDR_WIDTH  32  width of PC and imem address
//  MEM_DATA_WIDTH  32  width of instruction word / imem read data
//  FIFO_DEPTH      4   prefetch buffer entries; power of two, >= 2
//  RESET_PC        0   first fetch address after reset
//  PC_STEP         4   address increment per fetch; MEM_DATA_WIDTH/8 bytes
// PORTS
//  clk_i          in   1                        clock, rising edge
//  arst_ni        in   1                        asynchronous reset, active low
//  imem_req_o     out  1                        fetch request, held until imem_ack_i
//  imem_addr_o    out  MEM_ADDR_WIDTH           fetch address, stable while imem_req_o=1
//  imem_ack_i     in   1                        fetch complete; imem_rdata_i valid this cycle
//  imem_rdata_i   in   MEM_DATA_WIDTH           fetched instruction
//  redirect_i     in   1                        one-cycle pulse: restart fetch at redirect_pc_i
//  redirect_pc_i  in   MEM_ADDR_WIDTH           redirect target
//  instr_valid_o  out  1                        buffer head valid
//  instr_ready_i  in   1                        decode accepts head when instr_valid_o=1
//  instruction_o  out  MEM_DATA_WIDTH           head instruction
//  pc_out_o       out  MEM_ADDR_WIDTH           PC of head instruction
//  fifo_count_o   out  $clog2(FIFO_DEPTH+1)     occupied entries
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - State = IDLE; FIFO empty; fetch_pc = RESET_PC.
//   - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0,
//     instruction_o=0, pc_out_o=0, fifo_count_o=0.
//   - Reset mid-fetch drops the request; any later ack is ignored while in IDLE.
//  FSM states: IDLE, FETCH, DISCARD. imem_req_o=1 in FETCH and DISCARD, 0 in IDLE.
//  IDLE:
//   - count<DEPTH -> FETCH next cycle with addr=fetch_pc.
//   - First req therefore rises 1 cycle after reset release.
//  FETCH, ack=1, no redirect:
//   - Push {imem_addr_o, imem_rdata_i}; fetch_pc += PC_STEP (mod 2^MEM_ADDR_WIDTH).
//   - Stay in FETCH with the new addr if the post-update count<DEPTH, else go to IDLE.
//   - Throughput is 1 word/cycle with zero-wait memory.
//  Address rule: addr is never changed while req=1 and ack=0.
//  Redirect (redirect_i=1) has priority over everything:
//   - Flush the FIFO; count=0 next cycle.
//   - instr_valid_o is forced 0 in the redirect cycle, so no pop occurs.
//   - fetch_pc = redirect_pc_i with its log2(PC_STEP) LSBs cleared.
//   - IDLE, or FETCH with ack=1 (data dropped): FETCH next cycle at the new fetch_pc.
//   - FETCH with ack=0: go to DISCARD; req and old addr held.
//   - DISCARD with ack=0: target updated, stay. DISCARD with ack=1: data dropped, FETCH at the new fetch_pc.
//  DISCARD, ack=1, no redirect: drop data; FETCH next cycle at fetch_pc (FIFO empty).
//  FIFO:
//   - Push only from FETCH+ack.
//   - Issue requires count<DEPTH, so a push never overflows; a push is allowed when full only with a same-cycle pop.
//   - Pop when instr_valid_o & instr_ready_i.
//   - Push and pop in the same cycle: count unchanged.
//   - Pop on empty cannot occur because valid=0.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Head outputs:
//   - instr_valid_o = (count!=0) & !redirect_i.
//   - instruction_o/pc_out_o come from the head entry (registered storage).
//   - Head outputs hold their value when empty.
//  Latency: ack in cycle N -> instr_valid_o=1 in cycle N+1.
//  Flow control: instr_ready_i=0 with a full FIFO -> req drops to 0 within 1 cycle after the last ack.
// TESTING
//  1 Reset release, 0-wait ack every cycle, ready=1 -> addrs 0,4,8,... and pcs 0,4,8... in order, valid every cycle from cycle 2.
//  2 ready=0, ack every cycle, DEPTH=4 -> exactly 4 pushes, count=4, req=0; then ready=1 -> fetching resumes, order preserved.
//  3 Req at 0x10, ack delayed 3 cycles, redirect to 0x103 in cycle 1 -> addr stays 0x10 until ack, data dropped, next req addr=0x100, FIFO empty.
//  4 Redirect with 2 entries buffered and ack in the same cycle -> count=0 next cycle, pushed data dropped, next req at target.
//  5 redirect_pc=0xFFFFFFF8, sequential fetch -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap).
//  6 arst_ni low mid-FETCH with count=3 -> all outputs go to their reset values immediately; after release first req at RESET_PC.

Source files
------------

// File: rtl/instruction_prefetch.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time imem fetches and
// buffers {pc, instruction} pairs for decode, with redirect/flush support.
module instruction_prefetch #(
  parameter int                        MEM_ADDR_WIDTH = 32,
  parameter int                        MEM_DATA_WIDTH = 32,
  parameter int                        FIFO_DEPTH     = 4,
  parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int                        PC_STEP        = MEM_DATA_WIDTH / 8
) (
  input  logic                              clk_i,
  input  logic                              arst_ni,
  output logic                              imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0]         imem_addr_o,
  input  logic                              imem_ack_i,
  input  logic [MEM_DATA_WIDTH-1:0]         imem_rdata_i,
  input  logic                              redirect_i,
  input  logic [MEM_ADDR_WIDTH-1:0]         redirect_pc_i,
  output logic                              instr_valid_o,
  input  logic                              instr_ready_i,
  output logic [MEM_DATA_WIDTH-1:0]         instruction_o,
  output logic [MEM_ADDR_WIDTH-1:0]         pc_out_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_t;

  state_t                    state;
  logic                      req;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [MEM_ADDR_WIDTH-1:0] fetch_pc;

  logic [MEM_DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [MEM_ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             rd_ptr_inc;
  logic [CW-1:0]             count;
  logic [CW-1:0]             count_after;
  logic [MEM_DATA_WIDTH-1:0] head_instr;
  logic [MEM_ADDR_WIDTH-1:0] head_pc;

  logic                      valid;
  logic                      push;
  logic                      pop;
  logic                      room_after;
  logic [MEM_ADDR_WIDTH-1:0] target;
  logic [MEM_ADDR_WIDTH-1:0] next_seq;

  always_comb begin
    valid       = (count != '0) && !redirect_i;
    push        = (state == FETCH) && imem_ack_i && !redirect_i;
    pop         = valid && instr_ready_i;
    count_after = redirect_i ? '0 : (count + CW'(push) - CW'(pop));
    room_after  = count_after < CW'(FIFO_DEPTH);
    target      = redirect_pc_i & ~MEM_ADDR_WIDTH'(PC_STEP - 1);
    next_seq    = addr + MEM_ADDR_WIDTH'(PC_STEP);
    rd_ptr_inc  = rd_ptr + PW'(1);
  end

  // The address register only moves when no request is pending or the pending
  // one is being acked; fetch_pc holds a redirect target while DISCARD waits.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state    <= IDLE;
      req      <= 1'b0;
      addr     <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_i) begin
            fetch_pc <= target;
            addr     <= target;
            state    <= FETCH;
            req      <= 1'b1;
          end else if (count < CW'(FIFO_DEPTH)) begin
            addr  <= fetch_pc;
            state <= FETCH;
            req   <= 1'b1;
          end
        end
        FETCH: begin
          if (redirect_i) begin
            fetch_pc <= target;
            if (imem_ack_i) begin
              addr <= target;
            end else begin
              state <= DISCARD;
            end
          end else if (imem_ack_i) begin
            fetch_pc <= next_seq;
            addr     <= next_seq;
            if (!room_after) begin
              state <= IDLE;
              req   <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (redirect_i) begin
            fetch_pc <= target;
            if (imem_ack_i) begin
              addr  <= target;
              state <= FETCH;
            end
          end else if (imem_ack_i) begin
            addr  <= fetch_pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata_i;
      pc_mem[wr_ptr]   <= addr;
    end
  end

  // Head registers are reloaded only when the head entry changes, so they keep
  // their last value once the buffer drains or is flushed.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_instr <= '0;
      head_pc    <= '0;
    end else if (redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count <= count_after;
      if (push && ((count - CW'(pop)) == '0)) begin
        head_instr <= imem_rdata_i;
        head_pc    <= addr;
      end else if (pop && (count > CW'(1))) begin
        head_instr <= data_mem[rd_ptr_inc];
        head_pc    <= pc_mem[rd_ptr_inc];
      end
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = addr;
  assign instr_valid_o = valid;
  assign instruction_o = head_instr;
  assign pc_out_o      = head_pc;
  assign fifo_count_o  = count;

endmodule
